// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_arbiter_pkg
// Brief   : Shared requester-id type, memory mode width and size/sign codes.
// Revision: 1.0 - initial release
// ============================================================================
package data_mem_arbiter_pkg;

  localparam int MEM_SRC_WIDTH = 3;

  typedef logic req_id_t;
  localparam req_id_t REQ_CPU = 1'b0;
  localparam req_id_t REQ_DBG = 1'b1;

  // Size/sign encodings understood by the data memory
  localparam logic [MEM_SRC_WIDTH-1:0] MEM_SRC_B  = 3'd0;
  localparam logic [MEM_SRC_WIDTH-1:0] MEM_SRC_H  = 3'd1;
  localparam logic [MEM_SRC_WIDTH-1:0] MEM_SRC_W  = 3'd2;
  localparam logic [MEM_SRC_WIDTH-1:0] MEM_SRC_BU = 3'd4;
  localparam logic [MEM_SRC_WIDTH-1:0] MEM_SRC_HU = 3'd5;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_arbiter_if
// Brief   : Requester and memory-side signals of the two-port data arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_SRC_WIDTH = data_mem_arbiter_pkg::MEM_SRC_WIDTH
);
  logic                     req0, req1;
  logic                     we0, we1;
  logic [DATA_WIDTH-1:0]    addr0, addr1;
  logic [DATA_WIDTH-1:0]    wdata0, wdata1;
  logic [MEM_SRC_WIDTH-1:0] src0, src1;
  logic                     ack0, ack1;
  logic [DATA_WIDTH-1:0]    rdata;
  logic [DATA_WIDTH-1:0]    mem_a;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic                     mem_we;
  logic [MEM_SRC_WIDTH-1:0] mem_src;
  logic [DATA_WIDTH-1:0]    mem_rd;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, src0, src1,
    output ack0, ack1, rdata,
    output mem_a, mem_wd, mem_we, mem_src,
    input  mem_rd
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, src0, src1,
    input  ack0, ack1, rdata,
    input  mem_a, mem_wd, mem_we, mem_src,
    output mem_rd
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Brief   : Combinational two-way round-robin pick; ties go to the non-last id.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import data_mem_arbiter_pkg::*;
(
  input  logic [1:0] eligible,
  input  req_id_t    last,
  output logic       gnt_valid,
  output req_id_t    gnt_id
);

  always_comb begin
    gnt_valid = |eligible;
    gnt_id    = REQ_CPU;
    if (eligible == 2'b11) begin
      gnt_id = ~last;
    end else if (eligible[1]) begin
      gnt_id = REQ_DBG;
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_arbiter
// Brief   : Shares the data memory between core (id 0) and loader (id 1),
//           one access per cycle, registered read data and one-cycle ack.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_SRC_WIDTH = data_mem_arbiter_pkg::MEM_SRC_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus
);
  import data_mem_arbiter_pkg::*;

  req_id_t               last_q, last_d;
  req_id_t               resp_id_q, resp_id_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [1:0] eligible;
  logic       gnt_valid;
  req_id_t    gnt_id;
  logic       grant;

  // A request being acked this cycle is still high; mask it so it is not served twice.
  assign eligible[0] = bus.req0 & ~(resp_valid_q & (resp_id_q == REQ_CPU));
  assign eligible[1] = bus.req1 & ~(resp_valid_q & (resp_id_q == REQ_DBG));

  rr_arbiter2 u_rr_arbiter2 (
    .eligible  (eligible),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign grant = gnt_valid & ~rst;

  always_comb begin
    bus.mem_a   = bus.addr0;
    bus.mem_wd  = bus.wdata0;
    bus.mem_src = bus.src0;
    bus.mem_we  = 1'b0;
    if (grant) begin
      if (gnt_id == REQ_DBG) begin
        bus.mem_a   = bus.addr1;
        bus.mem_wd  = bus.wdata1;
        bus.mem_src = bus.src1;
        bus.mem_we  = bus.we1;
      end else begin
        bus.mem_we  = bus.we0;
      end
    end
  end

  always_comb begin
    last_d       = last_q;
    resp_id_d    = resp_id_q;
    resp_valid_d = grant;
    rdata_d      = rdata_q;
    if (grant) begin
      last_d    = gnt_id;
      resp_id_d = gnt_id;
      rdata_d   = bus.mem_rd;
    end
  end

  // last resets to the loader so the core wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= REQ_DBG;
      resp_id_q    <= REQ_CPU;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      last_q       <= last_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.ack0  = resp_valid_q & (resp_id_q == REQ_CPU);
  assign bus.ack1  = resp_valid_q & (resp_id_q == REQ_DBG);
  assign bus.rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_arbiter
// Brief   : Directed self-checking bench with a small word memory behind the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  int   n_vec  = 0;
  int   n_miss = 0;

  data_mem_arbiter_if #(.DATA_WIDTH(32), .MEM_SRC_WIDTH(3)) bus ();

  data_mem_arbiter #(.DATA_WIDTH(32), .MEM_SRC_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'hDEADBEEF;
      mem[12] <= 32'hCAFEF00D;
    end else if (bus.mem_we) begin
      mem[bus.mem_a[7:2]] <= bus.mem_wd;
    end
  end

  assign bus.mem_rd = mem[bus.mem_a[7:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;  mem_init = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0; bus.src0 = MEM_SRC_W;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0; bus.src1 = MEM_SRC_W;
    tick();
    mem_init = 1'b0;

    // Reset: a store request held during rst is neither written nor acked
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h44; bus.wdata0 = 32'h1;
    samp();
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_a",  bus.mem_a, 32'h44);
    chk("rst_ack0",   bus.ack0, 0);
    chk("rst_ack1",   bus.ack1, 0);
    chk("rst_rdata",  bus.rdata, 0);
    tick();
    rst = 1'b0; bus.req0 = 1'b0; bus.we0 = 1'b0;
    samp();
    chk("rst_no_ack0", bus.ack0, 0);
    chk("rst_mem44",   mem[17], 0);

    // Single load by the core
    tick();
    bus.req0 = 1'b1; bus.addr0 = 32'h10; bus.src0 = MEM_SRC_H;
    samp();
    chk("ld0_mem_a",   bus.mem_a, 32'h10);
    chk("ld0_mem_we",  bus.mem_we, 0);
    chk("ld0_mem_src", bus.mem_src, {29'b0, MEM_SRC_H});
    tick();
    samp();
    chk("ld0_ack0",  bus.ack0, 1);
    chk("ld0_ack1",  bus.ack1, 0);
    chk("ld0_rdata", bus.rdata, 32'hDEADBEEF);
    tick();
    bus.req0 = 1'b0; bus.src0 = MEM_SRC_W;
    samp();
    chk("ld0_no_regrant", bus.ack0, 0);
    chk("ld0_rdata_hold", bus.rdata, 32'hDEADBEEF);

    // Both requesters held from reset: grants 0,1,0,1,0 one per cycle
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 32'h10;
    bus.req1 = 1'b1; bus.addr1 = 32'h30;
    for (int k = 0; k < 5; k++) begin
      samp();
      chk($sformatf("alt%0d_mem_a", k), bus.mem_a, (k % 2 == 0) ? 32'h10 : 32'h30);
      chk($sformatf("alt%0d_ack0", k), bus.ack0, (k >= 1 && (k % 2 == 1)) ? 1 : 0);
      chk($sformatf("alt%0d_ack1", k), bus.ack1, (k >= 2 && (k % 2 == 0)) ? 1 : 0);
      if (k >= 1)
        chk($sformatf("alt%0d_rdata", k), bus.rdata,
            (k % 2 == 1) ? 32'hDEADBEEF : 32'hCAFEF00D);
      tick();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();

    // Loader alone, request held: ack1 every other cycle
    bus.req1 = 1'b1; bus.addr1 = 32'h30;
    for (int k = 0; k < 4; k++) begin
      samp();
      chk($sformatf("solo%0d_ack1", k), bus.ack1, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("solo%0d_mem_a", k), bus.mem_a, (k % 2 == 0) ? 32'h30 : 32'h10);
      tick();
    end
    bus.req1 = 1'b0;
    tick();

    // Loader store then core load of the same word in the next cycle
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h20; bus.wdata1 = 32'h12345678;
    samp();
    chk("st1_mem_we", bus.mem_we, 1);
    chk("st1_mem_a",  bus.mem_a, 32'h20);
    chk("st1_mem_wd", bus.mem_wd, 32'h12345678);
    tick();
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h20;
    samp();
    chk("st1_ack1",    bus.ack1, 1);
    chk("raw_mem_a",   bus.mem_a, 32'h20);
    chk("raw_mem_we",  bus.mem_we, 0);
    tick();
    bus.req0 = 1'b0;
    samp();
    chk("raw_ack0",  bus.ack0, 1);
    chk("raw_rdata", bus.rdata, 32'h12345678);

    // Reset rises in the grant cycle of a store to 0x30
    tick();
    rst = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h30; bus.wdata0 = 32'h0BADF00D;
    samp();
    chk("rstst_mem_we", bus.mem_we, 0);
    tick();
    rst = 1'b0; bus.req0 = 1'b0; bus.we0 = 1'b0;
    samp();
    chk("rstst_ack0",  bus.ack0, 0);
    chk("rstst_ack1",  bus.ack1, 0);
    chk("rstst_rdata", bus.rdata, 0);
    chk("rstst_mem30", mem[12], 32'hCAFEF00D);
    tick();
    bus.req0 = 1'b1; bus.addr0 = 32'h30;
    tick();
    bus.req0 = 1'b0;
    samp();
    chk("rstst_ld_ack0",  bus.ack0, 1);
    chk("rstst_ld_rdata", bus.rdata, 32'hCAFEF00D);

    // last is now the core: a tie goes to the loader, then the core
    tick();
    bus.req0 = 1'b1; bus.addr0 = 32'h10;
    bus.req1 = 1'b1; bus.addr1 = 32'h30; bus.we1 = 1'b0;
    samp();
    chk("tie_first_mem_a", bus.mem_a, 32'h30);
    tick();
    samp();
    chk("tie_ack1",         bus.ack1, 1);
    chk("tie_rdata1",       bus.rdata, 32'hCAFEF00D);
    chk("tie_second_mem_a", bus.mem_a, 32'h10);
    tick();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    samp();
    chk("tie_ack0",   bus.ack0, 1);
    chk("tie_rdata0", bus.rdata, 32'hDEADBEEF);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
